// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 16-bit memory bus (requester 0 = JTAG, 1 = core).
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; default is fixed priority to requester 0.
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [15:0]       r0_wdata,
    output logic [15:0]       r0_rdata,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [15:0]       r1_wdata,
    output logic [15:0]       r1_rdata,
    output logic              r1_done,
    output logic              bus_en,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;

    logic              w_grant_any;
    logic              w_grant_idx;
    logic              w_done_pulse;
    logic              w_cap_rdata;

    logic              w_bus_en;
    logic              w_bus_wr;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [15:0]       w_bus_wdata;
    logic              w_owner;
    logic              w_busy;
    logic              w_r0_done;
    logic              w_r1_done;

    logic              r_bus_en;
    logic              r_bus_wr;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [15:0]       r_bus_wdata;
    logic              r_owner;
    logic              r_busy;
    logic              r_r0_done;
    logic              r_r1_done;
    logic [15:0]       r_r0_rdata;
    logic [15:0]       r_r1_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_owner;

    // Reset value of 1 makes requester 0 win the first tie after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_last_owner <= 1'b1;
        else if (r_state == ST_IDLE && w_grant_any)
            r_last_owner <= w_grant_idx;
    end
`endif

    always_comb begin
        w_grant_any = r0_req | r1_req;
        w_grant_idx = 1'b0;
        if (r0_req && r1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_idx = ~r_last_owner;
`else
            w_grant_idx = 1'b0;
`endif
        end else if (r1_req) begin
            w_grant_idx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_any) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_WAIT;
            ST_WAIT:   if (r_cnt == 4'd0) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the next state.
    always_comb begin
        w_bus_en     = (w_next_state == ST_ACCESS);
        w_busy       = (w_next_state != ST_IDLE);
        w_bus_wr     = r_bus_wr;
        w_bus_addr   = r_bus_addr;
        w_bus_wdata  = r_bus_wdata;
        w_owner      = r_owner;
        if (r_state == ST_IDLE && w_grant_any) begin
            w_owner = w_grant_idx;
            if (w_grant_idx) begin
                w_bus_wr    = r1_wr;
                w_bus_addr  = r1_addr;
                w_bus_wdata = r1_wdata;
            end else begin
                w_bus_wr    = r0_wr;
                w_bus_addr  = r0_addr;
                w_bus_wdata = r0_wdata;
            end
        end
        w_done_pulse = (r_state == ST_WAIT) && (w_next_state == ST_DONE);
        w_r0_done    = w_done_pulse && !r_owner;
        w_r1_done    = w_done_pulse && r_owner;
        w_cap_rdata  = w_done_pulse && !r_bus_wr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= 4'd0;
            r_bus_en    <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= 16'd0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_r0_done   <= 1'b0;
            r_r1_done   <= 1'b0;
            r_r0_rdata  <= 16'd0;
            r_r1_rdata  <= 16'd0;
        end else begin
            if (r_state == ST_ACCESS)
                r_cnt <= LP_WAIT;
            else if (r_state == ST_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            r_bus_en    <= w_bus_en;
            r_bus_wr    <= w_bus_wr;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_owner     <= w_owner;
            r_busy      <= w_busy;
            r_r0_done   <= w_r0_done;
            r_r1_done   <= w_r1_done;
            if (w_cap_rdata && !r_owner)
                r_r0_rdata <= bus_rdata;
            if (w_cap_rdata && r_owner)
                r_r1_rdata <= bus_rdata;
        end
    end

    assign bus_en    = r_bus_en;
    assign bus_wr    = r_bus_wr;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign r0_done   = r_r0_done;
    assign r1_done   = r_r1_done;
    assign r0_rdata  = r_r0_rdata;
    assign r1_rdata  = r_r1_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed accesses push expected bus cycles and
// completions; a negedge monitor pops and compares them. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;

    localparam int W = 1;

    logic        clk;
    logic        rstn;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [15:0] r0_rdata, r1_rdata;
    logic        r0_done, r1_done;
    logic        bus_en, bus_wr;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        owner, busy;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_done(r0_done),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_done(r1_done),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: fixed read data per address.
    always_comb begin
        case (bus_addr)
            16'h0002: bus_rdata = 16'hBEEF;
            16'h0003: bus_rdata = 16'h1234;
            default:  bus_rdata = 16'hDEAD;
        endcase
    end

    typedef struct {
        int          idx;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          gap;
    } bus_exp_t;

    typedef struct {
        int          idx;
        logic [15:0] r0;
        logic [15:0] r1;
    } done_exp_t;

    bus_exp_t    busQ[$];
    done_exp_t   doneQ[$];
    logic [15:0] mRdata0 = 16'd0;
    logic [15:0] mRdata1 = 16'd0;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic pushExpect(input int idx, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input int gap, input bit withDone);
        bus_exp_t  b;
        done_exp_t d;
        b.idx = idx; b.wr = wr; b.addr = addr; b.wdata = wdata; b.gap = gap;
        busQ.push_back(b);
        if (withDone) begin
            if (!wr) begin
                if (idx == 0) mRdata0 = rdata;
                else          mRdata1 = rdata;
            end
            d.idx = idx; d.r0 = mRdata0; d.r1 = mRdata1;
            doneQ.push_back(d);
        end
    endtask

    // Holds req for 'count' accesses, dropping it in the cycle of the last done.
    task automatic applyStimulus(input int idx, input int count, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        int got = 0;
        int waitCnt = 0;
        if (idx == 0) begin
            r0_req = 1'b1; r0_wr = wr; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = 1'b1; r1_wr = wr; r1_addr = addr; r1_wdata = wdata;
        end
        while (got < count && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
            if ((idx == 0 && r0_done) || (idx == 1 && r1_done)) begin
                got++;
                waitCnt = 0;
            end
        end
        if (got < count) checkOutput("req_timeout", 32'(got), 32'(count));
        if (idx == 0) r0_req = 1'b0;
        else          r1_req = 1'b0;
    endtask

    bus_exp_t  mb;
    done_exp_t md;
    int        lastBusEn = 0;
    logic      prevBusEn = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus_en) begin
                checkOutput("bus_en_width", 32'(prevBusEn), 32'd0);
                if (busQ.size() == 0) begin
                    checkOutput("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    mb = busQ.pop_front();
                    checkOutput("bus_owner", 32'(owner), 32'(mb.idx));
                    checkOutput("bus_wr", 32'(bus_wr), 32'(mb.wr));
                    checkOutput("bus_addr", 32'(bus_addr), 32'(mb.addr));
                    checkOutput("bus_wdata", 32'(bus_wdata), 32'(mb.wdata));
                    if (mb.gap != 0)
                        checkOutput("bus_gap", 32'(cycle - lastBusEn), 32'(mb.gap));
                end
                lastBusEn = cycle;
            end
            if (r0_done || r1_done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("done_unexpected", 32'd1, 32'd0);
                end else begin
                    md = doneQ.pop_front();
                    checkOutput("done_who", 32'({r1_done, r0_done}), (md.idx == 0) ? 32'd1 : 32'd2);
                    checkOutput("done_latency", 32'(cycle - lastBusEn), 32'(W + 2));
                    checkOutput("r0_rdata", 32'(r0_rdata), 32'(md.r0));
                    checkOutput("r1_rdata", 32'(r1_rdata), 32'(md.r1));
                    checkOutput("busy_in_done", 32'(busy), 32'd1);
                end
            end
        end
        prevBusEn = bus_en;
    end

    initial begin
        int waitCnt;
        rstn = 1'b0;
        r0_req = 1'b0; r0_wr = 1'b0; r0_addr = 16'd0; r0_wdata = 16'd0;
        r1_req = 1'b0; r1_wr = 1'b0; r1_addr = 16'd0; r1_wdata = 16'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Idle after reset: nothing moves for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_ctl", 32'({bus_en, busy, r0_done, r1_done}), 32'd0);
            checkOutput("idle_owner", 32'(owner), 32'd0);
        end

        // Single read by requester 0, then single write by requester 1.
        pushExpect(0, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, 0, 1'b1);
        applyStimulus(0, 1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk);
        checkOutput("busy_after", 32'(busy), 32'd0);
        pushExpect(1, 1'b1, 16'h0001, 16'h00A5, 16'h0000, 0, 1'b1);
        applyStimulus(1, 1, 1'b1, 16'h0001, 16'h00A5);
        repeat (2) @(negedge clk);
        checkOutput("owner_last", 32'(owner), 32'd1);

        // Both request together and each holds for two accesses.
`ifdef ARB_ROUND_ROBIN_EN
        pushExpect(0, 1'b0, 16'h0003, 16'h0000, 16'h1234, 0, 1'b1);
        pushExpect(1, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, W + 4, 1'b1);
        pushExpect(0, 1'b0, 16'h0003, 16'h0000, 16'h1234, W + 4, 1'b1);
        pushExpect(1, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, W + 4, 1'b1);
`else
        pushExpect(0, 1'b0, 16'h0003, 16'h0000, 16'h1234, 0, 1'b1);
        pushExpect(0, 1'b0, 16'h0003, 16'h0000, 16'h1234, W + 4, 1'b1);
        pushExpect(1, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, W + 4, 1'b1);
        pushExpect(1, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, W + 4, 1'b1);
`endif
        fork
            applyStimulus(0, 2, 1'b0, 16'h0003, 16'h0000);
            applyStimulus(1, 2, 1'b0, 16'h0002, 16'h0000);
        join
        repeat (2) @(negedge clk);

        // Requester 1 arrives while requester 0 is in WAIT.
        pushExpect(0, 1'b1, 16'h0004, 16'h1111, 16'h0000, 0, 1'b1);
        pushExpect(1, 1'b0, 16'h0005, 16'h0000, 16'hDEAD, W + 4, 1'b1);
        fork
            applyStimulus(0, 1, 1'b1, 16'h0004, 16'h1111);
            begin
                waitCnt = 0;
                do begin
                    @(negedge clk);
                    waitCnt++;
                end while (!bus_en && waitCnt < 50);
                @(negedge clk);
                applyStimulus(1, 1, 1'b0, 16'h0005, 16'h0000);
            end
        join
        repeat (2) @(negedge clk);

        // Reset pulsed during WAIT aborts the access with no done.
        pushExpect(0, 1'b0, 16'h0002, 16'h0000, 16'hBEEF, 0, 1'b0);
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 16'h0002; r0_wdata = 16'h0000;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!bus_en && waitCnt < 50);
        checkOutput("rst_test_bus_en", 32'(bus_en), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("rst_ctl", 32'({bus_en, busy, r0_done, r1_done, owner, bus_wr}), 32'd0);
        checkOutput("rst_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus_wdata), 32'd0);
        checkOutput("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
        r0_req = 1'b0;
        doneQ.delete();
        mRdata0 = 16'd0;
        mRdata1 = 16'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_rst", 32'({r0_done, r1_done, bus_en}), 32'd0);
        end
        pushExpect(1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 0, 1'b1);
        applyStimulus(1, 1, 1'b0, 16'h0003, 16'h0000);

        repeat (5) @(negedge clk);
        checkOutput("busQ_left", 32'(busQ.size()), 32'd0);
        checkOutput("doneQ_left", 32'(doneQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory bus between two masters and serialises their accesses to the bus-attached peripherals (I2C controller, RAM, etc.).
- Requester 0 is the JTAG memory/debug controller; requester 1 is the processor core.
- Each granted access is presented to the bus as exactly one bus_en cycle, followed by a fixed wait before read data is captured and returned.

Parameters:
- WAIT_CYCLES, 1, cycles between the bus_en cycle and read-data capture; legal range 0..15.
- ADDR_W, 16, address width of requesters and bus.

Ports:
- clk  in  1  system clock (divided clock from the PLL block)
- rstn  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 (JTAG) access request; level, held until r0_done
- r0_wr  in  1  1=write, 0=read; stable while r0_req
- r0_addr  in  ADDR_W  access address; stable while r0_req
- r0_wdata  in  16  write data; stable while r0_req
- r0_rdata  out  16  registered read data
- r0_done  out  1  one-cycle completion pulse
- r1_req, r1_wr, r1_addr, r1_wdata, r1_rdata, r1_done: same as r0_*, for requester 1 (core)
- bus_en  out  1  bus access strobe; high for exactly one cycle per access
- bus_wr  out  1  bus write flag
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  16  bus write data
- bus_rdata  in  16  bus read data, valid WAIT_CYCLES cycles after the bus_en cycle
- owner  out  1  index of the current or last granted requester
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; outputs all 0, including bus_*, r*_rdata, r*_done, owner and busy.
- All outputs are registered. last_owner resets to 1.
- States: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples the requests.
  - Neither request high: stay in IDLE.
  - One request high: grant that requester.
  - Both high: requester 0 wins (see Optional Feature).
  - On grant: latch wr/addr/wdata into the bus_* registers, set owner, go to ACCESS.
- ACCESS: bus_en=1 for this cycle only; load the wait counter with WAIT_CYCLES; go to WAIT.
- WAIT:
  - bus_en=0. bus_addr, bus_wr and bus_wdata hold their values.
  - Counter decrements each cycle; at 0, go to DONE.
  - With WAIT_CYCLES=0, WAIT lasts exactly one cycle and samples bus_rdata in that cycle.
- Read-data capture: on the WAIT->DONE edge, if the access is a read, bus_rdata is registered into the owner's rdata.
  - The non-owner's rdata is unchanged.
  - On a write, both rdata registers are unchanged.
- DONE:
  - The owner's done=1 for exactly one cycle; requests are not sampled.
  - Next state is IDLE.
  - Requester drops req at the edge ending the done cycle, unless it wants another access.
- Latency: req first high at edge k, granted in IDLE -> bus_en high in cycle k+1 -> done high in cycle k+3+WAIT_CYCLES. A read with WAIT_CYCLES=1 takes 4 cycles in total.
- Minimum spacing between successive bus_en pulses: WAIT_CYCLES+4 cycles.
- A request arriving while busy waits; it is sampled in the next IDLE. Requests are never dropped or queued beyond that level.
- A req deasserted before done is a protocol violation. The arbiter still completes the transaction and pulses done.
- Reset mid-transaction aborts immediately: bus_en and done are forced low, and no partial done pulse appears after reset release.
- Address and data pass through at full width; no arithmetic or truncation. The counter is 4 bits.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, the grant goes to the requester that is not last_owner, and last_owner updates on each grant. After reset, requester 0 wins the first tie.
- Undefined: fixed priority; requester 0 always wins ties, and last_owner logic is omitted. Requester 1 can be starved by continuous JTAG traffic, which is accepted for debug use.

Test Plan:
- Reset, no requests -> bus_en, busy, r0_done and r1_done all stay 0 for 20 cycles; owner=0.
- r0 read addr 0x0002, bus_rdata=0xBEEF, WAIT_CYCLES=1:
  - bus_en high exactly once with bus_addr=0x0002, bus_wr=0.
  - r0_done pulses 3 cycles after bus_en; r0_rdata=0xBEEF; r1_rdata=0.
- r1 write addr 0x0001, data 0x00A5 -> one bus_en cycle with bus_wr=1, bus_wdata=0x00A5; owner=1; r1_done pulses once; r1_rdata unchanged.
- r0 and r1 both request in the same cycle:
  - Fixed priority: r0 serviced first, then r1.
  - With ARB_ROUND_ROBIN_EN and both held continuously: grants alternate 0,1,0,1.
- r1 requests while an r0 access is in WAIT -> r1 bus_en occurs exactly WAIT_CYCLES+4 cycles after r0's bus_en.
- rstn pulsed low during WAIT -> all outputs 0 immediately; no done pulse; the next request after release completes normally.
